// File: rtl/coax_port_switch_pkg.sv
// rtl/coax_port_switch_pkg.sv - mode and FSM state encodings shared by the coax port switch
package coax_port_switch_pkg;

   typedef enum logic [1:0] {
      MODE_NORMAL   = 2'b00,
      MODE_LOOPBACK = 2'b01,
      MODE_SCAN     = 2'b10,
      MODE_RESERVED = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_TX    = 2'b01,
      ST_GUARD = 2'b10
   } state_e;

   // The reserved encoding behaves exactly like NORMAL, so it is folded at load time.
   function automatic mode_e decode_mode(input logic [1:0] raw);
      mode_e m;
      case (raw)
         2'b01:   m = MODE_LOOPBACK;
         2'b10:   m = MODE_SCAN;
         default: m = MODE_NORMAL;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/coax_activity_detector.sv
// rtl/coax_activity_detector.sv - per-port RX synchroniser and carrier-sense counter
module coax_activity_detector #(
   parameter int SYNC_STAGES = 2,
   parameter int WINDOW      = 64,
   localparam int CW         = $clog2(WINDOW + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic rx_raw,
   output logic rx_sync,
   output logic active
);

   localparam logic [CW-1:0] SAT = CW'(WINDOW);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   // Shift the raw pin through the synchroniser; restart the quiet-time count on any synced edge.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rx_raw};
      prev_d = sync_q[SYNC_STAGES-1];
      cnt_d  = cnt_q;
      if (sync_q[SYNC_STAGES-1] ^ prev_q) begin
         cnt_d = '0;
      end else if (cnt_q != SAT) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter resets saturated so every port reads inactive until it sees an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         cnt_q  <= SAT;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
      end
   end

   assign rx_sync = sync_q[SYNC_STAGES-1];
   assign active  = (cnt_q < SAT);

endmodule

// File: rtl/coax_port_switch.sv
// rtl/coax_port_switch.sv - routes one coax TX/RX engine pair onto NUM_PORTS coax ports
module coax_port_switch
   import coax_port_switch_pkg::*;
#(
   parameter int NUM_PORTS      = 4,
   parameter int CLOCKS_PER_BIT = 16,
   parameter int GUARD_BITS     = 2,
   parameter int ACTIVITY_BITS  = 4,
   parameter int SYNC_STAGES    = 2,
   localparam int PW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           cfg_mode,
   input  logic [PW-1:0]        cfg_port,
   input  logic                 cfg_strobe,
   output logic                 cfg_reject,
   input  logic                 tx_active_in,
   input  logic                 tx_in,
   output logic                 rx_out,
   output logic [NUM_PORTS-1:0] port_tx_active,
   output logic [NUM_PORTS-1:0] port_tx,
   input  logic [NUM_PORTS-1:0] port_rx,
   output logic [NUM_PORTS-1:0] port_activity,
   output logic [PW-1:0]        cur_port,
   output logic                 busy
);

   localparam int G  = GUARD_BITS * CLOCKS_PER_BIT;
   localparam int GW = $clog2(G + 1);
   localparam int W  = ACTIVITY_BITS * CLOCKS_PER_BIT;
   localparam logic [GW-1:0] GUARD_LAST = GW'(G - 1);

   state_e                 state_q, state_d;
   mode_e                  mode_q, mode_d;
   logic [PW-1:0]          cur_port_q, cur_port_d;
   logic [GW-1:0]          guard_q, guard_d;
   logic                   cfg_reject_q, cfg_reject_d;
   logic                   rx_out_q, rx_out_d;
   logic [NUM_PORTS-1:0]   port_tx_active_q, port_tx_active_d;
   logic [NUM_PORTS-1:0]   port_tx_q, port_tx_d;

   logic [NUM_PORTS-1:0]   rx_sync;
   logic [NUM_PORTS-1:0]   tx_mask;
   logic                   port_ok;
   logic                   scan_hit;
   logic [PW-1:0]          scan_port;
   int                     idx;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      coax_activity_detector #(
         .SYNC_STAGES (SYNC_STAGES),
         .WINDOW      (W)
      ) u_activity (
         .clk     (clk),
         .reset_n (reset_n),
         .rx_raw  (port_rx[g]),
         .rx_sync (rx_sync[g]),
         .active  (port_activity[g])
      );
   end

   // When the port field can encode only valid ports, every request is in range.
   if (NUM_PORTS == (1 << PW)) begin : g_port_full
      assign port_ok = 1'b1;
   end else begin : g_port_range
      assign port_ok = (cfg_port < PW'(NUM_PORTS));
   end

   // Scan priority: first active port after cur_port, wrapping through 0 back up to cur_port-1.
   always_comb begin
      scan_hit  = 1'b0;
      scan_port = cur_port_q;
      idx       = 0;
      for (int i = 1; i < NUM_PORTS; i++) begin
         idx = int'(cur_port_q) + i;
         if (idx >= NUM_PORTS) begin
            idx = idx - NUM_PORTS;
         end
         if (!scan_hit && port_activity[PW'(idx)]) begin
            scan_hit  = 1'b1;
            scan_port = PW'(idx);
         end
      end
   end

   // Config load, scan step, TX/GUARD FSM and next values of the registered outputs.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      cur_port_d   = cur_port_q;
      guard_d      = guard_q;
      cfg_reject_d = 1'b0;

      if (cfg_strobe) begin
         if (state_q == ST_IDLE && port_ok) begin
            mode_d     = decode_mode(cfg_mode);
            cur_port_d = cfg_port;
         end else begin
            cfg_reject_d = 1'b1;
         end
      end else if (state_q == ST_IDLE && mode_q == MODE_SCAN &&
                   !port_activity[cur_port_q] && scan_hit) begin
         cur_port_d = scan_port;
      end

      case (state_q)
         ST_IDLE: begin
            guard_d = '0;
            if (tx_active_in && mode_d != MODE_LOOPBACK) begin
               state_d = ST_TX;
            end
         end
         ST_TX: begin
            guard_d = '0;
            if (!tx_active_in) begin
               state_d = ST_GUARD;
            end
         end
         ST_GUARD: begin
            if (tx_active_in) begin
               state_d = ST_TX;
               guard_d = '0;
            end else if (guard_q == GUARD_LAST) begin
               state_d = ST_IDLE;
               guard_d = '0;
            end else begin
               guard_d = guard_q + GW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            guard_d = '0;
         end
      endcase

      // Outputs follow the next state/port so a same-cycle config or scan switch drives the new port.
      tx_mask          = (state_d == ST_TX) ? (NUM_PORTS'(1) << cur_port_d) : '0;
      port_tx_active_d = tx_mask;
      port_tx_d        = tx_in ? tx_mask : '0;

      if (mode_q == MODE_LOOPBACK) begin
         rx_out_d = tx_in;
      end else if (state_d == ST_IDLE && cur_port_d == cur_port_q) begin
         rx_out_d = rx_sync[cur_port_q];
      end else begin
         rx_out_d = 1'b0;
      end
   end

   // State and output registers; reset drops every driver enable immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         mode_q           <= MODE_NORMAL;
         cur_port_q       <= '0;
         guard_q          <= '0;
         cfg_reject_q     <= 1'b0;
         rx_out_q         <= 1'b0;
         port_tx_active_q <= '0;
         port_tx_q        <= '0;
      end else begin
         state_q          <= state_d;
         mode_q           <= mode_d;
         cur_port_q       <= cur_port_d;
         guard_q          <= guard_d;
         cfg_reject_q     <= cfg_reject_d;
         rx_out_q         <= rx_out_d;
         port_tx_active_q <= port_tx_active_d;
         port_tx_q        <= port_tx_d;
      end
   end

   assign cfg_reject     = cfg_reject_q;
   assign rx_out         = rx_out_q;
   assign port_tx_active = port_tx_active_q;
   assign port_tx        = port_tx_q;
   assign cur_port       = cur_port_q;
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_coax_port_switch.sv
// tb/tb_coax_port_switch.sv - directed bench for coax_port_switch
module tb_coax_port_switch;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] cfg_mode;
   logic [1:0] cfg_port;
   logic [1:0] cfg_port3;
   logic       cfg_strobe;
   logic       tx_active_in;
   logic       tx_in;
   logic [3:0] port_rx;

   logic       cfg_reject, rx_out, busy;
   logic [3:0] port_tx_active, port_tx, port_activity;
   logic [1:0] cur_port;

   logic       cfg_reject3, rx_out3, busy3;
   logic [2:0] port_tx_active3, port_tx3, port_activity3;
   logic [1:0] cur_port3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   coax_port_switch u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg_mode       (cfg_mode),
      .cfg_port       (cfg_port),
      .cfg_strobe     (cfg_strobe),
      .cfg_reject     (cfg_reject),
      .tx_active_in   (tx_active_in),
      .tx_in          (tx_in),
      .rx_out         (rx_out),
      .port_tx_active (port_tx_active),
      .port_tx        (port_tx),
      .port_rx        (port_rx),
      .port_activity  (port_activity),
      .cur_port       (cur_port),
      .busy           (busy)
   );

   coax_port_switch #(.NUM_PORTS(3)) u_dut3 (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg_mode       (cfg_mode),
      .cfg_port       (cfg_port3),
      .cfg_strobe     (cfg_strobe),
      .cfg_reject     (cfg_reject3),
      .tx_active_in   (tx_active_in),
      .tx_in          (tx_in),
      .rx_out         (rx_out3),
      .port_tx_active (port_tx_active3),
      .port_tx        (port_tx3),
      .port_rx        (port_rx[2:0]),
      .port_activity  (port_activity3),
      .cur_port       (cur_port3),
      .busy           (busy3)
   );

   typedef struct {
      logic [1:0] mode;
      logic [1:0] port;
      logic       strobe;
      logic       txa;
      logic       txd;
      logic [3:0] e_pta;
      logic [3:0] e_ptx;
      logic       e_rx;
      logic [1:0] e_cur;
      logic       e_busy;
      logic       e_rej;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic found;
      logic [3:0] pat;

      vecs[0] = '{2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
      vecs[1] = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
      vecs[2] = '{2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0};
      vecs[3] = '{2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1};
      vecs[4] = '{2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0};
      vecs[5] = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0};
      vecs[6] = '{2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1};

      reset_n = 1'b0;
      cfg_mode = 2'd0; cfg_port = 2'd0; cfg_port3 = 2'd0; cfg_strobe = 1'b0;
      tx_active_in = 1'b0; tx_in = 1'b0; port_rx = 4'b0000;
      repeat (3) step();
      chk("reset_pta", port_tx_active, 4'b0000);
      chk("reset_busy", busy, 1'b0);
      chk("reset_cur", cur_port, 2'd0);
      chk("reset_act", port_activity, 4'b0000);
      chk("reset_rx", rx_out, 1'b0);
      reset_n = 1'b1;
      repeat (2) step();

      // Out-of-range port on a 3-port instance is rejected, in-range accepted
      cfg_port3 = 2'd3; cfg_strobe = 1'b1;
      step();
      cfg_strobe = 1'b0;
      chk("p3_reject", cfg_reject3, 1'b1);
      chk("p3_cur_hold", cur_port3, 2'd0);
      chk("p4_no_reject", cfg_reject, 1'b0);
      cfg_port3 = 2'd2; cfg_strobe = 1'b1;
      step();
      cfg_strobe = 1'b0;
      chk("p3_accept", cfg_reject3, 1'b0);
      chk("p3_cur_load", cur_port3, 2'd2);

      // Table: config, TX burst on port 2, rejected strobes during TX and GUARD
      for (int i = 0; i < 7; i++) begin
         cfg_mode = vecs[i].mode; cfg_port = vecs[i].port; cfg_strobe = vecs[i].strobe;
         tx_active_in = vecs[i].txa; tx_in = vecs[i].txd;
         step();
         chk($sformatf("v%0d_pta", i), port_tx_active, vecs[i].e_pta);
         chk($sformatf("v%0d_ptx", i), port_tx, vecs[i].e_ptx);
         chk($sformatf("v%0d_rx", i), rx_out, vecs[i].e_rx);
         chk($sformatf("v%0d_cur", i), cur_port, vecs[i].e_cur);
         chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
         chk($sformatf("v%0d_rej", i), cfg_reject, vecs[i].e_rej);
      end
      cfg_strobe = 1'b0;

      // Guard: 32 cycles after TX falls, rx muted; then rx follows port_rx[2] with 3-cycle latency
      port_rx = 4'b0100;
      for (int k = 2; k < 32; k++) begin
         step();
         chk("guard_busy", busy, 1'b1);
         chk("guard_rx", rx_out, 1'b0);
      end
      step();
      chk("guard_end_busy", busy, 1'b0);
      chk("guard_end_rx", rx_out, 1'b1);
      port_rx = 4'b0000;
      step(); chk("lat1_rx", rx_out, 1'b1);
      step(); chk("lat2_rx", rx_out, 1'b1);
      step(); chk("lat3_rx", rx_out, 1'b0);

      // TX re-asserted at guard cycle 10 restarts TX and clears the guard count
      port_rx = 4'b0100;
      tx_active_in = 1'b1;
      step();
      chk("rt_pta", port_tx_active, 4'b0100);
      tx_active_in = 1'b0;
      step();
      for (int k = 0; k < 10; k++) begin
         step();
         chk("rt_guard_rx", rx_out, 1'b0);
      end
      tx_active_in = 1'b1;
      step();
      chk("rt_pta2", port_tx_active, 4'b0100);
      chk("rt_rx2", rx_out, 1'b0);
      tx_active_in = 1'b0;
      step();
      for (int k = 1; k < 32; k++) begin
         step();
         chk("rt2_busy", busy, 1'b1);
         chk("rt2_rx", rx_out, 1'b0);
      end
      step();
      chk("rt2_end_busy", busy, 1'b0);
      chk("rt2_end_rx", rx_out, 1'b1);

      // Asynchronous reset in the middle of TX
      tx_active_in = 1'b1;
      step();
      chk("pre_rst_pta", port_tx_active, 4'b0100);
      #3;
      reset_n = 1'b0;
      port_rx = 4'b0000;
      #1;
      chk("mid_rst_pta", port_tx_active, 4'b0000);
      chk("mid_rst_ptx", port_tx, 4'b0000);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_cur", cur_port, 2'd0);
      chk("mid_rst_act", port_activity, 4'b0000);
      tx_active_in = 1'b0;
      step();
      reset_n = 1'b1;
      step();

      // Loopback: rx_out mirrors tx_in one cycle later, no port driven
      cfg_mode = 2'b01; cfg_port = 2'd0; cfg_strobe = 1'b1;
      step();
      cfg_strobe = 1'b0;
      tx_active_in = 1'b1;
      pat = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
         tx_in = pat[i];
         step();
         chk("lb_rx", rx_out, pat[i]);
         chk("lb_pta", port_tx_active, 4'b0000);
         chk("lb_busy", busy, 1'b0);
      end
      tx_active_in = 1'b0; tx_in = 1'b0;

      // Scan from port 0 with no active ports: hold
      cfg_mode = 2'b10; cfg_port = 2'd0; cfg_strobe = 1'b1;
      step();
      cfg_strobe = 1'b0;
      repeat (5) step();
      chk("scan_idle_cur", cur_port, 2'd0);

      // Activity on port 3 only: scan locks onto it
      port_rx[3] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (cur_port == 2'd3) found = 1'b1;
      end
      chk("scan_found3", found, 1'b1);
      chk("scan_act3", port_activity, 4'b1000);
      for (int t = 0; t < 2; t++) begin
         port_rx[3] = ~port_rx[3];
         repeat (4) begin
            step();
            chk("scan_lock3", cur_port, 2'd3);
         end
      end

      // Stop toggling: activity clears exactly 64 cycles after the last synced edge
      port_rx[3] = ~port_rx[3];
      repeat (66) step();
      chk("quiet_still_active", port_activity[3], 1'b1);
      step();
      chk("quiet_inactive", port_activity[3], 1'b0);
      repeat (3) step();
      chk("quiet_hold3", cur_port, 2'd3);

      // Ports 1 and 2 become active: search wraps past 3 and picks 1 first
      port_rx[1] = 1'b1; port_rx[2] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (cur_port != 2'd3) found = 1'b1;
      end
      chk("wrap_switched", found, 1'b1);
      chk("wrap_cur", cur_port, 2'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
